// File: rtl/t_ff_toggle_decoder.sv
// ============================================================================
// Module   : t_ff_toggle_decoder
// Brief    : Recovers the T stream from the SR/JK/D T-flip-flop Q outputs,
//            cross-checks the three Qs, counts toggles/disagreements and
//            latches a sticky fault. Optional macro: TOGGLE_VOTE_EN
//            (majority-voted sample, fault only after err_cnt saturates).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module t_ff_toggle_decoder #(
  parameter int CNT_W = 8,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             Q_SR,
  input  logic             Q_JK,
  input  logic             Q_D,
  output logic             T_rec,
  output logic             T_valid,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fault,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_FAULT = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_ZERO = '0;
  localparam logic [ERR_W-1:0] C_ERR_ZERO = '0;
  localparam logic [ERR_W-1:0] C_ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             q_prev_q, q_prev_d;
  logic             t_rec_q, t_rec_d;
  logic             t_valid_q, t_valid_d;
  logic [CNT_W-1:0] tog_q, tog_d;
  logic             mism_q, mism_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic q_sel;
  logic disagree;
  logic err_sat;
  logic fault_trig;
  logic toggle;

  assign disagree = en & ~((Q_SR == Q_JK) && (Q_JK == Q_D));
  assign err_sat  = &err_q;

`ifdef TOGGLE_VOTE_EN
  // Voting masks a single bad flop; only a persistent problem is fatal.
  assign q_sel      = (Q_SR & Q_JK) | (Q_SR & Q_D) | (Q_JK & Q_D);
  assign fault_trig = disagree & err_sat;
`else
  assign q_sel      = Q_D;
  assign fault_trig = disagree;
`endif

  assign toggle = q_sel ^ q_prev_q;

  always_comb begin
    state_d   = state_q;
    q_prev_d  = q_prev_q;
    t_rec_d   = t_rec_q;
    t_valid_d = 1'b0;
    tog_d     = tog_q;
    mism_d    = 1'b0;
    err_d     = err_q;

    if (clr) begin
      state_d = S_IDLE;
      tog_d   = C_CNT_ZERO;
      err_d   = C_ERR_ZERO;
      t_rec_d = 1'b0;
    end else if (en) begin
      mism_d = disagree;
      if (disagree && !err_sat) begin
        err_d = err_q + C_ERR_ONE;
      end
      case (state_q)
        S_RUN: begin
          // The sample that trips the fault still updates T_rec/toggle_cnt.
          t_rec_d  = toggle;
          tog_d    = tog_q + {{(CNT_W-1){1'b0}}, toggle};
          q_prev_d = q_sel;
          if (fault_trig) begin
            state_d = S_FAULT;
          end else begin
            t_valid_d = 1'b1;
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          q_prev_d = q_sel;
          state_d  = S_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      q_prev_q  <= 1'b0;
      t_rec_q   <= 1'b0;
      t_valid_q <= 1'b0;
      tog_q     <= C_CNT_ZERO;
      mism_q    <= 1'b0;
      err_q     <= C_ERR_ZERO;
    end else begin
      state_q   <= state_d;
      q_prev_q  <= q_prev_d;
      t_rec_q   <= t_rec_d;
      t_valid_q <= t_valid_d;
      tog_q     <= tog_d;
      mism_q    <= mism_d;
      err_q     <= err_d;
    end
  end

  assign T_rec      = t_rec_q;
  assign T_valid    = t_valid_q;
  assign toggle_cnt = tog_q;
  assign mismatch   = mism_q;
  assign err_cnt    = err_q;
  assign fault      = (state_q == S_FAULT);
  assign state      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_t_ff_toggle_decoder.sv
// ============================================================================
// Module   : tb_t_ff_toggle_decoder
// Brief    : Scoreboard bench for t_ff_toggle_decoder; a behavioural model
//            queues the expected outputs, a monitor compares each cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_t_ff_toggle_decoder;

  localparam int CNT_W = 8;
  localparam int ERR_W = 4;

  logic clk = 1'b0;
  logic rst, en, clr, q_sr, q_jk, q_d;
  logic             T_rec, T_valid, mismatch, fault;
  logic [CNT_W-1:0] toggle_cnt;
  logic [ERR_W-1:0] err_cnt;
  logic [1:0]       state;

  always #5 clk = ~clk;

  t_ff_toggle_decoder #(.CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .Q_SR(q_sr), .Q_JK(q_jk), .Q_D(q_d),
    .T_rec(T_rec), .T_valid(T_valid), .toggle_cnt(toggle_cnt),
    .mismatch(mismatch), .err_cnt(err_cnt), .fault(fault), .state(state)
  );

  typedef struct {
    int t_rec, t_valid, tog, mism, err, fault, state;
  } exp_t;

  exp_t expq[$];
  int checks = 0;
  int errors = 0;

  // Reference model: "have a previous sample", "faulted", plain integer counters.
  bit m_have, m_fault, m_prev, m_trec, m_tvalid, m_mism;
  int m_tog, m_err;

  task automatic chk(input string name, input logic [31:0] got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.t_rec   = m_trec;
    e.t_valid = m_tvalid;
    e.tog     = m_tog;
    e.mism    = m_mism;
    e.err     = m_err;
    e.fault   = m_fault;
    e.state   = m_fault ? 2 : (m_have ? 1 : 0);
    return e;
  endfunction

  task automatic model_reset();
    m_have = 0; m_fault = 0; m_prev = 0; m_trec = 0; m_tvalid = 0; m_mism = 0;
    m_tog = 0; m_err = 0;
  endtask

  task automatic model_step(input bit e, input bit c, input bit sr, input bit jk, input bit d);
    bit sel, dis, goflt, t;
    int err_before;
    if (c) begin
      m_have = 0; m_fault = 0; m_tog = 0; m_err = 0;
      m_tvalid = 0; m_mism = 0; m_trec = 0;
    end else if (e) begin
      err_before = m_err;
      dis = !(sr == jk && jk == d);
`ifdef TOGGLE_VOTE_EN
      sel   = (int'(sr) + int'(jk) + int'(d)) >= 2;
      goflt = dis && (err_before == (1 << ERR_W) - 1);
`else
      sel   = d;
      goflt = dis;
`endif
      m_mism = dis;
      if (dis && m_err < (1 << ERR_W) - 1) m_err++;
      if (m_fault) begin
        m_tvalid = 0;
      end else if (!m_have) begin
        m_have = 1; m_prev = sel; m_tvalid = 0;
      end else begin
        t = sel ^ m_prev;
        m_trec = t;
        m_tog = (m_tog + int'(t)) % (1 << CNT_W);
        m_prev = sel;
        m_fault = goflt;
        m_tvalid = !goflt;
      end
    end else begin
      m_tvalid = 0; m_mism = 0;
    end
  endtask

  task automatic step(input bit e, input bit c, input bit sr, input bit jk, input bit d);
    @(negedge clk);
    rst = 1; en = e; clr = c; q_sr = sr; q_jk = jk; q_d = d;
    model_step(e, c, sr, jk, d);
    expq.push_back(model_out());
  endtask

  task automatic samp(input bit q);
    step(1, 0, q, q, q);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_T_rec"}, T_rec, 0);
    chk({tag, "_T_valid"}, T_valid, 0);
    chk({tag, "_toggle_cnt"}, toggle_cnt, 0);
    chk({tag, "_mismatch"}, mismatch, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_state"}, state, 0);
  endtask

  // Reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic async_reset();
    @(negedge clk);
    #2 rst = 0;
    #1 check_zero("async_rst");
    model_reset();
    expq.push_back(model_out());
  endtask

  // Monitor: one expected entry per rising edge once stimulus starts.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("T_rec", T_rec, e.t_rec);
        chk("T_valid", T_valid, e.t_valid);
        chk("toggle_cnt", toggle_cnt, e.tog);
        chk("mismatch", mismatch, e.mism);
        chk("err_cnt", err_cnt, e.err);
        chk("fault", fault, e.fault);
        chk("state", state, e.state);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit b, sr, jk, d;
    rst = 0; en = 0; clr = 0; q_sr = 0; q_jk = 0; q_d = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("reset");

    // Sequence 0,0,1,1,0: T_rec 0,1,0,1 and toggle_cnt 2.
    samp(0); samp(0); samp(1); samp(1); samp(0);
    step(0, 0, 0, 0, 0);

    // 256 toggles from RUN wrap the counter back to 0.
    step(0, 1, 0, 0, 0);
    samp(0);
    for (int i = 0; i < 256; i++) samp(i[0] ? 1'b0 : 1'b1);
    step(0, 0, 0, 0, 0);

    // Single disagree in RUN, then clr+en together while faulted.
    samp(1);
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 1, 1);
    step(1, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0);

    // Repeated disagrees drive err_cnt to saturation.
    samp(0);
    for (int i = 0; i < 18; i++) step(1, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0);

    // toggle_cnt = 5 then asynchronous reset mid-cycle.
    samp(0); samp(1); samp(0); samp(1); samp(0); samp(1);
    async_reset();
    step(0, 0, 0, 0, 0);

    // Gap of en=0 keeps q_prev; next sample toggles.
    samp(0); samp(1);
    step(0, 0, 0, 0, 0); step(0, 0, 1, 1, 1); step(0, 0, 0, 1, 0);
    samp(0);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      b = 1'($urandom);
      sr = b; jk = b; d = b;
      if ($urandom_range(0, 9) == 0) begin
        sr = 1'($urandom); jk = 1'($urandom); d = 1'($urandom);
      end
      step($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, sr, jk, d);
    end

    repeat (3) @(negedge clk);
    chk("queue_drain", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
